// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline stall/bubble controller with load-use, flush and LDI/STI sequencing
// Optional performance counters: STALL_PERF_CNT_EN
module pipeline_stall_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_memread,
  input  logic                  if_mem_resp,
  input  logic                  mem_memread,
  input  logic                  mem_memwrite,
  input  logic                  mem_mem_resp,
  input  logic                  mem_indirect,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_uses_src1,
  input  logic                  id_uses_src2,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_memread,
  input  logic                  ex_br_taken,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] bubble,
  output logic                  ind_phase,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      ind_count
);

  typedef enum logic {IDLE = 1'b0, IND_DATA = 1'b1} ind_state_t;

  ind_state_t state;

  logic imiss, dmiss, ind_stall, hold_all, flush, lu;
  logic [NUM_STAGES-1:0] bubble_req;

  assign imiss = if_memread & ~if_mem_resp;
  assign dmiss = (mem_memread | mem_memwrite) & ~mem_mem_resp;
  // The pointer access is held even on its response; only the data response releases.
  assign ind_stall = (state == IDLE) ? mem_indirect : ~mem_mem_resp;
  assign hold_all  = dmiss | ind_stall;
  assign flush     = ex_br_taken;
  assign lu = ex_memread & ~ex_br_taken &
              ((id_uses_src1 & (id_src1 == ex_dest)) |
               (id_uses_src2 & (id_src2 == ex_dest)));

  always_comb begin
    stall      = '0;
    bubble_req = '0;
    if (hold_all) begin
      stall = '1;
    end else begin
      if (imiss | lu) stall[1:0] = 2'b11;
      if (flush) begin
        bubble_req[1] = 1'b1;
        bubble_req[2] = 1'b1;
      end else if (lu) begin
        bubble_req[2] = 1'b1;
      end
    end
    bubble = bubble_req & ~stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ind_phase <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_indirect & mem_mem_resp) begin
            state     <= IND_DATA;
            ind_phase <= 1'b1;
          end
        end
        IND_DATA: begin
          if (mem_mem_resp) begin
            state     <= IDLE;
            ind_phase <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          ind_phase <= 1'b0;
        end
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic ind_done;
  assign ind_done = (state == IND_DATA) & mem_mem_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      ind_count    <= '0;
    end else begin
      if (stall[0] && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (ind_done && (ind_count != '1))    ind_count    <= ind_count + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign ind_count    = '0;
`endif

endmodule
